// File: rtl/kolibri_clk_pkg.sv
// kolibri_clk_pkg: shared types and widths for the 6309E clock/wait-state logic
package kolibri_clk_pkg;
  localparam int CNT_W = 4;
  localparam int TCNT_W = 8;
  typedef enum logic [1:0] {IDLE, COUNT, VDPHOLD, RELEASE} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_ROM, SEL_IO, SEL_VDP} sel_t;
  function automatic sel_t sel_decode(input logic cs_rom_n, input logic cs_io_n, input logic cs_vdp_n);
    return !cs_vdp_n ? SEL_VDP : !cs_io_n ? SEL_IO : !cs_rom_n ? SEL_ROM : SEL_NONE;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser, resets to 1
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the asynchronous input through two flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b11;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/wait_gen.sv
// wait_gen: stretches E-high/Q-low bus phases for slow ROM, I/O and V9958 cycles
module wait_gen
  import kolibri_clk_pkg::*;
#(
  parameter int WS_ROM  = 1,
  parameter int WS_IO   = 2,
  parameter int WS_VDP  = 2,
  parameter int MAXWAIT = 200
) (
  input  logic MHZ48,
  input  logic nRESET,
  input  logic MHZ12,
  input  logic nE,
  input  logic nQ,
  input  logic nCS_ROM,
  input  logic nCS_IO,
  input  logic nCS_VDP,
  input  logic nVDPWAIT,
  output logic nWAIT,
  output logic TIMEOUT
);
  logic mhz12_q, ne_q, nq_q, vdpwait, is_vdp;
  logic tick, stall, nq_fall, ne_rise;
  state_t state;
  sel_t sel;
  logic [CNT_W-1:0] cnt, ws;
  logic [TCNT_W-1:0] tcnt, tnext;

  sync2 u_sync (.clk(MHZ48), .rst_n(nRESET), .d(nVDPWAIT), .q(vdpwait));

  assign tick    = MHZ12 & ~mhz12_q;
  assign stall   = ~nE & nQ;
  assign nq_fall = nq_q & ~nQ;
  assign ne_rise = ~ne_q & nE;
  assign sel     = sel_decode(nCS_ROM, nCS_IO, nCS_VDP);
  assign tnext   = &tcnt ? tcnt : tcnt + 1'b1;

  // wait-state count for whichever device wins priority
  always_comb
    ws = sel == SEL_VDP ? CNT_W'(WS_VDP) : sel == SEL_IO ? CNT_W'(WS_IO) : sel == SEL_ROM ? CNT_W'(WS_ROM) : '0;

  // previous levels of the clock-block signals for edge detection
  always_ff @(posedge MHZ48 or negedge nRESET)
    if (!nRESET) {mhz12_q, ne_q, nq_q} <= 3'b111;
    else {mhz12_q, ne_q, nq_q} <= {MHZ12, nE, nQ};

  // wait-state FSM; nWAIT and TIMEOUT are registered here
  always_ff @(posedge MHZ48 or negedge nRESET)
    if (!nRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      is_vdp  <= 1'b0;
      nWAIT   <= 1'b1;
      TIMEOUT <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (nq_fall && (sel == SEL_VDP || ws != '0)) begin
            state  <= COUNT;
            cnt    <= ws;
            is_vdp <= sel == SEL_VDP;
            nWAIT  <= 1'b0;
          end
        COUNT:
          if (cnt == '0 || (tick && stall && cnt == CNT_W'(1))) begin
            cnt <= '0;
            if (is_vdp) begin
              state <= VDPHOLD;
              tcnt  <= '0;
            end else begin
              state <= RELEASE;
              nWAIT <= 1'b1;
            end
          end else if (tick && stall) cnt <= cnt - 1'b1;
        VDPHOLD:
          if (vdpwait) begin
            state <= RELEASE;
            nWAIT <= 1'b1;
          end else if (tick && stall) begin
            tcnt <= tnext;
            if (tnext == TCNT_W'(MAXWAIT)) begin
              TIMEOUT <= 1'b1;
              state   <= RELEASE;
              nWAIT   <= 1'b1;
            end
          end
        RELEASE:
          if (ne_rise) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
